// File: rtl/bustap_pkg.sv
// Shared definitions for the bus tap trigger sequencer: FSM state
// encodings, trigger word field positions and small helpers that pick
// fields out of the accepted trigger word.
package bustap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int CFG_ARM      = 31;
  localparam int CFG_FORCE    = 30;
  localparam int CFG_POST_HI  = 29;
  localparam int CFG_POST_LO  = 16;
  localparam int CFG_MATCH_HI = 15;
  localparam int CFG_MATCH_LO = 0;

  localparam int POST_W  = CFG_POST_HI - CFG_POST_LO + 1;
  localparam int MATCH_W = CFG_MATCH_HI - CFG_MATCH_LO + 1;

  // Stability counter width; wide enough for STABLE_CYC up to 15.
  localparam int STAB_CNT_W = 4;

  // Post-trigger transaction count field of a trigger word.
  function automatic logic [POST_W-1:0] post_field(input logic [31:0] cfg);
    return cfg[CFG_POST_HI:CFG_POST_LO];
  endfunction

  // Address match field of a trigger word.
  function automatic logic [MATCH_W-1:0] match_field(input logic [31:0] cfg);
    return cfg[CFG_MATCH_HI:CFG_MATCH_LO];
  endfunction

endpackage

// File: rtl/bustap_cfg_sync.sv
// Brings the JTAG-side trigger word into the clk domain. Every bit goes
// through a two-flop synchronizer, and the word is only accepted once the
// synchronized value has held steady long enough that a multi-bit update
// cannot be caught half-way through.
module bustap_cfg_sync
  import bustap_pkg::*;
#(
  parameter int TRIG_W     = 32,
  parameter int STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TRIG_W-1:0] trig_cfg,
  output logic [TRIG_W-1:0] cfg_q,
  output logic              cfg_load
);

  // The counter saturates at CNT_MAX so a steady word is loaded once; the
  // load fires on the edge where the counter steps onto CNT_MAX.
  localparam logic [STAB_CNT_W-1:0] CNT_MAX  = STAB_CNT_W'(STABLE_CYC - 1);
  localparam logic [STAB_CNT_W-1:0] CNT_LOAD = STAB_CNT_W'(STABLE_CYC - 2);

  logic [TRIG_W-1:0]     sync1;
  logic [TRIG_W-1:0]     sync2;
  logic [TRIG_W-1:0]     prev;
  logic [STAB_CNT_W-1:0] stab_cnt;
  logic                  same;
  logic                  load;

  assign same = (sync2 == prev);
  assign load = same && (stab_cnt == CNT_LOAD);

  // Two-flop synchronizer plus a one-cycle history of the synchronized word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= trig_cfg;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Count consecutive identical synchronized samples; any change restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_cnt <= '0;
    end else if (!same) begin
      stab_cnt <= '0;
    end else if (stab_cnt != CNT_MAX) begin
      stab_cnt <= stab_cnt + STAB_CNT_W'(1);
    end
  end

  // Accept the word once it has proven stable; cfg_load marks the update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q    <= '0;
      cfg_load <= 1'b0;
    end else begin
      cfg_load <= load;
      if (load) begin
        cfg_q <= sync2;
      end
    end
  end

endmodule

// File: rtl/bustap_trig_ctrl.sv
// Trigger sequencer for the bus tap capture path. Arms on a rising edge of
// the accepted arm bit, captures pre-trigger traffic circularly, triggers on
// an address match or forced trigger, captures a programmed number of
// post-trigger transactions and then freezes the capture buffer.
module bustap_trig_ctrl
  import bustap_pkg::*;
#(
  parameter int TRIG_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int PTR_W      = 10,
  parameter int STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TRIG_W-1:0] trig_cfg,
  input  logic              bus_wr,
  input  logic              bus_rd,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [PTR_W-1:0]  cap_wptr,
  output logic              cap_wr,
  output logic              trig_hit,
  output logic [PTR_W-1:0]  trig_ptr,
  output logic              done,
  output logic [1:0]        state
);

  logic [TRIG_W-1:0] cfg_q;
  logic              cfg_load;
  state_t            state_q;
  logic [POST_W-1:0] post_cnt;
  logic              arm_prev;
  logic              arm;
  logic              arm_rise;
  logic              txn;
  logic              match;
  logic              trigger;
  logic              unused_ok;

  bustap_cfg_sync #(
    .TRIG_W     (TRIG_W),
    .STABLE_CYC (STABLE_CYC)
  ) u_cfg_sync (
    .clk      (clk),
    .rst      (rst),
    .trig_cfg (trig_cfg),
    .cfg_q    (cfg_q),
    .cfg_load (cfg_load)
  );

  // Upper address bits and the load strobe are not needed by the sequencer.
  assign unused_ok = ^{bus_addr[ADDR_W-1:MATCH_W], cfg_load};

  assign arm      = cfg_q[CFG_ARM];
  assign arm_rise = arm && !arm_prev;
  assign txn      = bus_wr | bus_rd;
  assign match    = txn && (bus_addr[MATCH_W-1:0] == match_field(cfg_q));
  // Match and force collapse into a single trigger condition, so both in
  // the same cycle still produce just one trigger.
  assign trigger  = match || (cfg_q[CFG_FORCE] && txn);

  assign state = state_q;

  // Capture every transaction while armed or collecting post-trigger data;
  // this is combinational so the write lands in the transaction's own cycle.
  always_comb begin
    cap_wr = 1'b0;
    if ((state_q == ST_ARMED) || (state_q == ST_POST)) begin
      cap_wr = txn;
    end
  end

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      arm_prev <= 1'b0;
      trig_hit <= 1'b0;
      trig_ptr <= '0;
      done     <= 1'b0;
      post_cnt <= '0;
    end else begin
      arm_prev <= arm;
      trig_hit <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          done <= 1'b0;
          if (arm_rise) begin
            state_q <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (!arm) begin
            state_q <= ST_IDLE;
          end else if (trigger) begin
            trig_hit <= 1'b1;
            trig_ptr <= cap_wptr;
            post_cnt <= post_field(cfg_q);
            if (post_field(cfg_q) == '0) begin
              state_q <= ST_DONE;
              done    <= 1'b1;
            end else begin
              state_q <= ST_POST;
            end
          end
        end
        ST_POST: begin
          if (!arm) begin
            state_q <= ST_IDLE;
          end else if (txn) begin
            post_cnt <= post_cnt - POST_W'(1);
            if (post_cnt == POST_W'(1)) begin
              state_q <= ST_DONE;
              done    <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (!arm) begin
            state_q <= ST_IDLE;
            done    <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bustap_trig_ctrl.sv
// Directed bench for the bus tap trigger sequencer. Transactions are driven
// on the falling edge, cap_wr is sampled before the rising edge that takes
// the transaction, and registered outputs are sampled just after it.
module tb_bustap_trig_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] trig_cfg;
  logic        bus_wr;
  logic        bus_rd;
  logic [31:0] bus_addr;
  logic [9:0]  cap_wptr;
  logic        cap_wr;
  logic        trig_hit;
  logic [9:0]  trig_ptr;
  logic        done;
  logic [1:0]  state;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [9:0]  wptr;
  logic [9:0]  last_ptr;
  logic [9:0]  saved_ptr;
  logic        capd;
  logic        hit;
  int          hits;

  bustap_trig_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .trig_cfg (trig_cfg),
    .bus_wr   (bus_wr),
    .bus_rd   (bus_rd),
    .bus_addr (bus_addr),
    .cap_wptr (cap_wptr),
    .cap_wr   (cap_wr),
    .trig_hit (trig_hit),
    .trig_ptr (trig_ptr),
    .done     (done),
    .state    (state)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // One single-cycle bus transaction; the bench plays the capture buffer,
  // advancing its write pointer whenever the DUT asks for a write.
  task automatic applyStimulus(input logic [15:0] addr, input bit rd,
                               output logic c, output logic h);
    @(negedge clk);
    bus_wr   = !rd;
    bus_rd   = rd;
    bus_addr = {16'hA5A5, addr};
    cap_wptr = wptr;
    #1 c = cap_wr;
    @(posedge clk);
    #1 h = trig_hit;
    bus_wr = 1'b0;
    bus_rd = 1'b0;
    last_ptr = wptr;
    if (c) wptr = wptr + 10'd1;
    if (h) hits++;
  endtask

  task automatic setCfg(input logic [31:0] v);
    @(negedge clk);
    trig_cfg = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic disarm(input string tag);
    setCfg(32'h0);
    idle(10);
    checkOutput({tag, " disarm state"}, 32'(state), 32'd0);
    checkOutput({tag, " disarm done"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; trig_cfg = 32'h0; bus_wr = 1'b0; bus_rd = 1'b0;
    bus_addr = 32'h0; wptr = 10'd100; cap_wptr = 10'd100; hits = 0;
    #12;
    checkOutput("reset state", 32'(state), 32'd0);
    checkOutput("reset cap_wr", 32'(cap_wr), 32'd0);
    checkOutput("reset trig_hit", 32'(trig_hit), 32'd0);
    checkOutput("reset trig_ptr", 32'(trig_ptr), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    @(negedge clk); rst = 1'b0;
    idle(3);
    applyStimulus(16'h1234, 1'b0, capd, hit);
    checkOutput("idle no capture", 32'(capd), 32'd0);

    // Test 1: arm, match at 0x1234, three post-trigger transactions.
    setCfg(32'h8003_1234);
    idle(10);
    checkOutput("t1 armed", 32'(state), 32'd1);
    hits = 0;
    applyStimulus(16'h0010, 1'b0, capd, hit);
    checkOutput("t1 pre0 cap", 32'(capd), 32'd1);
    applyStimulus(16'h0020, 1'b1, capd, hit);
    checkOutput("t1 pre1 cap", 32'(capd), 32'd1);
    checkOutput("t1 pre hit", 32'(hit), 32'd0);
    applyStimulus(16'h1234, 1'b0, capd, hit);
    saved_ptr = last_ptr;
    checkOutput("t1 trig cap", 32'(capd), 32'd1);
    checkOutput("t1 trig hit", 32'(hit), 32'd1);
    checkOutput("t1 trig_ptr", 32'(trig_ptr), 32'(saved_ptr));
    checkOutput("t1 post state", 32'(state), 32'd2);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(16'h0100 + 16'(i), i[0], capd, hit);
      checkOutput($sformatf("t1 post%0d cap", i), 32'(capd), (i < 3) ? 32'd1 : 32'd0);
      if (i == 2) begin
        checkOutput("t1 done state", 32'(state), 32'd3);
        checkOutput("t1 done", 32'(done), 32'd1);
      end
    end
    checkOutput("t1 hit count", 32'(hits), 32'd1);
    checkOutput("t1 trig_ptr held", 32'(trig_ptr), 32'(saved_ptr));
    disarm("t1");

    // Test 2: post_count of zero goes straight from ARMED to DONE.
    setCfg(32'h8000_00AA);
    idle(10);
    checkOutput("t2 armed", 32'(state), 32'd1);
    applyStimulus(16'h00AB, 1'b1, capd, hit);
    checkOutput("t2 miss cap", 32'(capd), 32'd1);
    checkOutput("t2 miss hit", 32'(hit), 32'd0);
    applyStimulus(16'h00AA, 1'b0, capd, hit);
    checkOutput("t2 trig cap", 32'(capd), 32'd1);
    checkOutput("t2 trig hit", 32'(hit), 32'd1);
    checkOutput("t2 direct done state", 32'(state), 32'd3);
    checkOutput("t2 done", 32'(done), 32'd1);
    applyStimulus(16'h00AA, 1'b0, capd, hit);
    checkOutput("t2 frozen cap", 32'(capd), 32'd0);
    disarm("t2");

    // Test 3: forced trigger, then force and match together.
    setCfg(32'hC001_0000);
    idle(10);
    checkOutput("t3 armed", 32'(state), 32'd1);
    applyStimulus(16'h5555, 1'b0, capd, hit);
    checkOutput("t3 force hit", 32'(hit), 32'd1);
    checkOutput("t3 force cap", 32'(capd), 32'd1);
    applyStimulus(16'h7777, 1'b1, capd, hit);
    checkOutput("t3 post cap", 32'(capd), 32'd1);
    checkOutput("t3 done state", 32'(state), 32'd3);
    disarm("t3");
    setCfg(32'hC001_0000);
    idle(10);
    hits = 0;
    applyStimulus(16'h0000, 1'b0, capd, hit);
    applyStimulus(16'h0000, 1'b0, capd, hit);
    checkOutput("t3 both hit count", 32'(hits), 32'd1);
    checkOutput("t3 both done state", 32'(state), 32'd3);
    disarm("t3b");

    // Test 4: disarm in the middle of a long post-trigger window.
    setCfg(32'h8064_0BEE);
    idle(10);
    applyStimulus(16'h0BEE, 1'b0, capd, hit);
    saved_ptr = last_ptr;
    checkOutput("t4 trig hit", 32'(hit), 32'd1);
    for (int i = 0; i < 10; i++) applyStimulus(16'h0200 + 16'(i), 1'b0, capd, hit);
    checkOutput("t4 still post", 32'(state), 32'd2);
    setCfg(32'h0064_0BEE);
    idle(5);
    checkOutput("t4 post before sync", 32'(state), 32'd2);
    idle(2);
    checkOutput("t4 idle after sync", 32'(state), 32'd0);
    checkOutput("t4 done", 32'(done), 32'd0);
    checkOutput("t4 trig_ptr held", 32'(trig_ptr), 32'(saved_ptr));
    applyStimulus(16'h0BEE, 1'b0, capd, hit);
    checkOutput("t4 idle cap", 32'(capd), 32'd0);

    // Test 5: a two-cycle glitch on arm is filtered, a held arm is taken.
    setCfg(32'h8000_0000);
    idle(2);
    trig_cfg = 32'h0;
    idle(12);
    checkOutput("t5 glitch filtered", 32'(state), 32'd0);
    setCfg(32'h8000_0000);
    idle(10);
    checkOutput("t5 held arm", 32'(state), 32'd1);

    // Test 6: asynchronous reset while armed, then re-arm after reload.
    @(negedge clk);
    bus_wr = 1'b1; bus_addr = 32'h0000_1111;
    #1 checkOutput("t6 pre-reset cap", 32'(cap_wr), 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("t6 reset cap_wr", 32'(cap_wr), 32'd0);
    checkOutput("t6 reset state", 32'(state), 32'd0);
    checkOutput("t6 reset trig_ptr", 32'(trig_ptr), 32'd0);
    checkOutput("t6 reset done", 32'(done), 32'd0);
    bus_wr = 1'b0;
    @(negedge clk); rst = 1'b0;
    idle(5);
    checkOutput("t6 idle during reload", 32'(state), 32'd0);
    idle(2);
    checkOutput("t6 rearmed", 32'(state), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
